// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache with a four-beat line-fill controller.
// Optional hit/miss statistics counters are enabled with ICACHE_STATS_EN.
module icache_ctrl #(
    parameter int LINES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  Pc_in,
    input  logic         Rd_en,
    input  logic         Jmp_branch_valid,
    output logic [127:0] Dout,
    output logic         Dout_valid,
    output logic         Mem_req,
    output logic [31:0]  Mem_addr,
    input  logic         Mem_ack,
    input  logic [31:0]  Mem_data,
    input  logic         Mem_data_valid
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]  Hit_count,
    output logic [15:0]  Miss_count
`endif
);
    localparam int IDX = $clog2(LINES);
    localparam int TW  = 30 - IDX;

    typedef enum logic [1:0] {IDLE, REQ, FILL, INSTALL} state_t;

    state_t            state;
    logic [LINES-1:0]  valid;
    logic [TW-1:0]     tag_mem  [LINES];
    logic [127:0]      data_mem [LINES];
    logic [3:0][31:0]  fill_buf;
    logic [TW-1:0]     miss_tag;
    logic [IDX-1:0]    miss_idx;
    logic [1:0]        beat;

    logic [IDX-1:0]    idx;
    logic [TW-1:0]     tag;
    logic              present;
    logic              hit;
    logic              miss;
    logic              unused_ok;

    assign idx       = Pc_in[IDX+1:2];
    assign tag       = Pc_in[31:IDX+2];
    assign unused_ok = ^Pc_in[1:0];

    // Lookups are only honoured in IDLE; a redirect masks both hit and miss.
    assign present    = valid[idx] && (tag_mem[idx] == tag);
    assign hit        = (state == IDLE) && Rd_en && present && !Jmp_branch_valid;
    assign miss       = (state == IDLE) && Rd_en && !present && !Jmp_branch_valid;
    assign Dout_valid = hit;
    assign Dout       = hit ? data_mem[idx] : '0;
    assign Mem_addr   = {miss_tag, miss_idx, 2'b00};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            valid    <= '0;
            miss_tag <= '0;
            miss_idx <= '0;
            beat     <= '0;
            Mem_req  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (miss) begin
                    miss_tag <= tag;
                    miss_idx <= idx;
                    Mem_req  <= 1'b1;
                    state    <= REQ;
                end
                REQ: if (Mem_ack) begin
                    Mem_req <= 1'b0;
                    beat    <= '0;
                    state   <= FILL;
                end
                FILL: if (Mem_data_valid) begin
                    beat <= beat + 2'd1;
                    if (beat == 2'd3)
                        state <= INSTALL;
                end
                INSTALL: begin
                    valid[miss_idx] <= 1'b1;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage arrays carry no reset; the valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (state == FILL && Mem_data_valid)
            fill_buf[beat] <= Mem_data;
        if (state == INSTALL) begin
            data_mem[miss_idx] <= fill_buf;
            tag_mem[miss_idx]  <= miss_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            Hit_count  <= '0;
            Miss_count <= '0;
        end else begin
            if (hit && Hit_count != 16'hFFFF)
                Hit_count <= Hit_count + 16'd1;
            if (miss && Miss_count != 16'hFFFF)
                Miss_count <= Miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed test-plan scenarios followed by
// randomized lookups/fills checked against an array-based cache model.
module tb_icache_ctrl;
    localparam int LINES = 16;
    localparam int IDX   = $clog2(LINES);

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  Pc_in = '0;
    logic         Rd_en = 1'b0;
    logic         Jmp_branch_valid = 1'b0;
    logic [127:0] Dout;
    logic         Dout_valid;
    logic         Mem_req;
    logic [31:0]  Mem_addr;
    logic         Mem_ack = 1'b0;
    logic [31:0]  Mem_data = '0;
    logic         Mem_data_valid = 1'b0;
`ifdef ICACHE_STATS_EN
    logic [15:0]  Hit_count;
    logic [15:0]  Miss_count;
`endif

    icache_ctrl #(.LINES(LINES)) dut (
        .clk(clk), .reset(reset), .Pc_in(Pc_in), .Rd_en(Rd_en),
        .Jmp_branch_valid(Jmp_branch_valid), .Dout(Dout), .Dout_valid(Dout_valid),
        .Mem_req(Mem_req), .Mem_addr(Mem_addr), .Mem_ack(Mem_ack),
        .Mem_data(Mem_data), .Mem_data_valid(Mem_data_valid)
`ifdef ICACHE_STATS_EN
        , .Hit_count(Hit_count), .Miss_count(Miss_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: what each line holds, plus expected statistics.
    bit           m_valid [LINES];
    logic [31:0]  m_base  [LINES];
    logic [127:0] m_data  [LINES];
    int           m_hits, m_miss;
    int           n_chk, n_err;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_miss = 0;
    endtask

    // One IDLE-state lookup cycle; reports whether the model expects a miss.
    task automatic lookup(input logic [31:0] pc, input bit rd, input bit jmp, output bit is_miss);
        int  i;
        bit  res;
        @(negedge clk);
        Pc_in = pc; Rd_en = rd; Jmp_branch_valid = jmp;
        Mem_ack = 1'b0; Mem_data_valid = 1'b0;
        #1;
        i   = (pc >> 2) % LINES;
        res = m_valid[i] && (m_base[i] == {pc[31:2], 2'b00} - ((pc[31:2] % LINES) << 2) + (i << 2));
        chk("hit_valid", {127'd0, Dout_valid}, {127'd0, rd && res && !jmp});
        chk("hit_data", Dout, (rd && res && !jmp) ? m_data[i] : 128'd0);
        chk("idle_req", {127'd0, Mem_req}, 128'd0);
        if (rd && res && !jmp) m_hits++;
        is_miss = rd && !res && !jmp;
        if (is_miss) m_miss++;
    endtask

    task automatic do_fill(input logic [31:0] addr, input int ack_wait, input int gap,
                           input logic [127:0] line, input int jmp_beat, input int rst_beat,
                           input logic [31:0] pc_during);
        for (int w = 0; w <= ack_wait; w++) begin
            @(negedge clk);
            Pc_in = pc_during; Rd_en = 1'b1; Jmp_branch_valid = $urandom_range(0, 1);
            Mem_ack = (w == ack_wait);
            #1;
            chk("req_hi", {127'd0, Mem_req}, 128'd1);
            chk("req_addr", {96'd0, Mem_addr}, {96'd0, addr});
            chk("req_dv", {127'd0, Dout_valid}, 128'd0);
        end
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                Mem_ack = 1'b0; Mem_data_valid = 1'b0; Jmp_branch_valid = 1'b0;
                #1;
                chk("gap_req", {127'd0, Mem_req}, 128'd0);
                chk("gap_addr", {96'd0, Mem_addr}, {96'd0, addr});
                chk("gap_dv", {127'd0, Dout_valid}, 128'd0);
            end
            @(negedge clk);
            Mem_ack = 1'b0; Mem_data_valid = 1'b1; Mem_data = line[b*32 +: 32];
            Jmp_branch_valid = (b == jmp_beat);
            if (b == jmp_beat) Pc_in = 32'h80;
            #1;
            chk("fill_req", {127'd0, Mem_req}, 128'd0);
            chk("fill_addr", {96'd0, Mem_addr}, {96'd0, addr});
            chk("fill_dv", {127'd0, Dout_valid}, 128'd0);
            if (b == rst_beat) begin
                @(negedge clk);
                reset = 1'b0; Rd_en = 1'b0; Mem_data_valid = 1'b0; Jmp_branch_valid = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                Mem_data_valid = 1'b1; Mem_data = 32'hDEAD_BEEF;  // orphaned beat
                #1;
                chk("rst_req", {127'd0, Mem_req}, 128'd0);
                chk("rst_addr", {96'd0, Mem_addr}, 128'd0);
                model_clear();
                return;
            end
        end
        @(negedge clk);
        Mem_data_valid = 1'b0; Jmp_branch_valid = 1'b0;
        #1;
        chk("inst_dv", {127'd0, Dout_valid}, 128'd0);
        chk("inst_req", {127'd0, Mem_req}, 128'd0);
        chk("inst_addr", {96'd0, Mem_addr}, {96'd0, addr});
        m_valid[(addr >> 2) % LINES] = 1'b1;
        m_base[(addr >> 2) % LINES]  = addr;
        m_data[(addr >> 2) % LINES]  = line;
    endtask

    task automatic access(input logic [31:0] pc, input bit expect_miss, input logic [127:0] line,
                          input int ack_wait, input int gap, input int jmp_beat, input int rst_beat);
        bit m;
        lookup(pc, 1'b1, 1'b0, m);
        chk("miss_kind", {127'd0, m}, {127'd0, expect_miss});
        if (m) do_fill({pc[31:2], 2'b00}, ack_wait, gap, line, jmp_beat, rst_beat, pc);
    endtask

    localparam logic [127:0] L40 = 128'h44444444_33333333_22222222_11111111;

    initial begin
        bit           m;
        logic [31:0]  pc;
        logic [127:0] ln;
        n_chk = 0; n_err = 0;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req0", {127'd0, Mem_req}, 128'd0);
        chk("rst_addr0", {96'd0, Mem_addr}, 128'd0);
        chk("rst_dv0", {127'd0, Dout_valid}, 128'd0);
        @(negedge clk);
        reset = 1'b1;

        // Cold miss, then hit two cycles after the last beat
        access(32'h40, 1'b1, L40, 0, 0, -1, -1);
        access(32'h40, 1'b0, 128'd0, 0, 0, -1, -1);
        chk("cold_data", Dout, L40);

        // Hit streaming on consecutive cycles
        access(32'h44, 1'b1, {4{32'hA5A5_0044}}, 1, 0, -1, -1);
        access(32'h40, 1'b0, 128'd0, 0, 0, -1, -1);
        access(32'h44, 1'b0, 128'd0, 0, 0, -1, -1);

        // Conflict eviction on index 0
        access(32'h440, 1'b1, {4{32'h0440_0440}}, 0, 0, -1, -1);
        access(32'h40, 1'b1, L40, 0, 1, -1, -1);

        // Redirect during fill: 0x40 still installs, then 0x80 misses
        access(32'h440, 1'b1, {4{32'h0440_0440}}, 0, 0, -1, -1);
        access(32'h40, 1'b1, L40, 0, 0, 1, -1);
        access(32'h40, 1'b0, 128'd0, 0, 0, -1, -1);
        access(32'h80, 1'b1, {4{32'h0080_0080}}, 0, 0, -1, -1);

        // Stalled memory: late ack, two-cycle gaps between beats
        access(32'hC8, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 5, 2, -1, -1);
        access(32'hC8, 1'b0, 128'd0, 0, 0, -1, -1);

        // Reset mid-fill, retried line misses, then 3 hits + 1 miss
        access(32'h40, 1'b1, L40, 0, 0, -1, 2);
`ifdef ICACHE_STATS_EN
        chk("stat_rst_h", {112'd0, Hit_count}, 128'd0);
        chk("stat_rst_m", {112'd0, Miss_count}, 128'd0);
`endif
        access(32'h40, 1'b1, L40, 0, 0, -1, -1);
        repeat (3) access(32'h40, 1'b0, 128'd0, 0, 0, -1, -1);
        @(negedge clk);
        Rd_en = 1'b0;
        #1;
`ifdef ICACHE_STATS_EN
        chk("stat_hits", {112'd0, Hit_count}, 128'd3);
        chk("stat_miss", {112'd0, Miss_count}, 128'd1);
`endif

        // Randomized traffic over a few tags per index
        for (int it = 0; it < 200; it++) begin
            pc = ($urandom_range(0, 3) << (IDX + 2)) | ($urandom_range(0, LINES - 1) << 2)
                 | $urandom_range(0, 3);
            lookup(pc, $urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0, m);
            if (m) begin
                ln = {$urandom, $urandom, $urandom, $urandom};
                do_fill({pc[31:2], 2'b00}, $urandom_range(0, 3), $urandom_range(0, 2), ln,
                        $urandom_range(0, 4) - 1, -1,
                        ($urandom_range(0, 3) << (IDX + 2)) | ($urandom_range(0, LINES - 1) << 2));
            end
        end
        @(negedge clk);
        Rd_en = 1'b0; Jmp_branch_valid = 1'b0;
        #1;
`ifdef ICACHE_STATS_EN
        chk("stat_hits_rnd", {112'd0, Hit_count}, m_hits);
        chk("stat_miss_rnd", {112'd0, Miss_count}, m_miss);
`endif
        chk("final_req", {127'd0, Mem_req}, 128'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
